// File: rtl/apb_master_bridge.sv
// APB master bridge: turns single cmd requests into APB SETUP/ACCESS transfers with a
// timeout abort and an optional extra cycle for sampling registered read data.
module apb_master_bridge #(
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned RDATA_LAG = 1
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [7:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StRdwait} state_e;

  localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        psel_d, penable_d, pwrite_d;
  logic [7:0]  paddr_d;
  logic [31:0] pwdata_d, rdata_d;
  logic        rsp_valid_d, rsp_err_d;

  assign cmd_ready = (state_q == StIdle);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err;
    rdata_d     = rsp_rdata;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d   = StSetup;
          cnt_d     = '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
      end
      StAccess: begin
        cnt_d = cnt_q + 8'd1;
        if (PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (PWRITE || RDATA_LAG == 0) begin
            state_d     = StIdle;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            if (!PWRITE) rdata_d = PRDATA;
          end else begin
            state_d = StRdwait;
          end
        end else if (cnt_q == LastCnt) begin
          // Slave never answered within the budget: abort with an error response.
          state_d     = StIdle;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rdata_d     = '0;
        end
      end
      StRdwait: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rdata_d     = PRDATA;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a lag-1 instance against a registering slave model
// and a lag-0 instance fed directly, with response expectations held in queues.
module tb_apb_master_bridge;

  typedef struct packed {
    logic        err;
    logic        chk_data;
    logic [31:0] rdata;
  } exp_t;

  logic        PCLK, PRESETn;
  logic        cmd_valid, cmd_valid0, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        PREADY;
  logic [31:0] PRDATA, slv_rdata, direct_rdata;
  logic        use_direct;

  logic        cmd_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE;
  logic [31:0] rsp_rdata, PWDATA;
  logic [7:0]  PADDR;
  logic        cmd_ready0, rsp_valid0, rsp_err0, PSEL0, PENABLE0, PWRITE0;
  logic [31:0] rsp_rdata0, PWDATA0;
  logic [7:0]  PADDR0;

  logic [31:0] mem [256];
  exp_t        q1[$];
  exp_t        q0[$];
  int          n_vec, n_err;
  int          cyc, n_setup, n_access, n_access0, acc_cnt, acc_cyc, acc_gap;

  assign PRDATA = use_direct ? direct_rdata : slv_rdata;

  apb_master_bridge #(.TIMEOUT(16), .RDATA_LAG(1)) u_dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  apb_master_bridge #(.TIMEOUT(16), .RDATA_LAG(0)) u_dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .PSEL(PSEL0), .PENABLE(PENABLE0), .PWRITE(PWRITE0), .PADDR(PADDR0), .PWDATA(PWDATA0),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave for the lag-1 instance: stores writes, registers read data on the completing edge.
  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PREADY) begin
      if (PWRITE) mem[PADDR] <= PWDATA;
      else        slv_rdata  <= mem[PADDR];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    exp_t e;
    logic acc;
    acc = cmd_ready && cmd_valid;
    @(posedge PCLK);
    #1;
    cyc++;
    if (acc) begin
      acc_gap = cyc - acc_cyc;
      acc_cyc = cyc;
      acc_cnt++;
    end
    if (PSEL && !PENABLE) n_setup++;
    if (PSEL && PENABLE) n_access++;
    if (PSEL0 && PENABLE0) n_access0++;
    if (rsp_valid) begin
      chk("rsp expected (u_dut)", 64'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("rsp_err (u_dut)", rsp_err, e.err);
        if (e.chk_data) chk("rsp_rdata (u_dut)", rsp_rdata, e.rdata);
      end
    end
    if (rsp_valid0) begin
      chk("rsp expected (u_dut0)", 64'(q0.size() > 0), 1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("rsp_err (u_dut0)", rsp_err0, e.err);
        if (e.chk_data) chk("rsp_rdata (u_dut0)", rsp_rdata0, e.rdata);
      end
    end
  endtask

  initial begin
    int  base, base2;
    logic done;
    n_vec = 0; n_err = 0; cyc = 0; n_setup = 0; n_access = 0; n_access0 = 0;
    acc_cnt = 0; acc_cyc = 0; acc_gap = 0;
    cmd_valid = 0; cmd_valid0 = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    PREADY = 1; use_direct = 0; direct_rdata = '0; slv_rdata = '0;
    PRESETn = 1;
    #1 PRESETn = 0;

    // Reset state
    tick(); tick();
    chk("rst PSEL", PSEL, 0);
    chk("rst PENABLE", PENABLE, 0);
    chk("rst PWRITE", PWRITE, 0);
    chk("rst PADDR", PADDR, 0);
    chk("rst PWDATA", PWDATA, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_err", rsp_err, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst u_dut0 ctl", {PSEL0, PENABLE0, rsp_valid0, cmd_ready0}, 4'b0001);
    PRESETn = 1;
    tick();

    // Write 0x10 <- DEADBEEF, PREADY high
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h10; cmd_wdata = 32'hDEADBEEF;
    q1.push_back('{err: 1'b0, chk_data: 1'b0, rdata: 32'h0});
    tick();
    cmd_valid = 0;
    chk("wr SETUP", {PSEL, PENABLE, cmd_ready}, 3'b100);
    chk("wr PADDR/PWRITE", {PWRITE, PADDR}, {1'b1, 8'h10});
    chk("wr PWDATA", PWDATA, 32'hDEADBEEF);
    tick();
    chk("wr ACCESS", {PSEL, PENABLE}, 2'b11);
    tick();
    chk("wr rsp_valid", rsp_valid, 1);
    chk("wr idle", {PSEL, PENABLE, cmd_ready}, 3'b001);

    // Read back 0x10 through the lag-1 path
    cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h10;
    q1.push_back('{err: 1'b0, chk_data: 1'b1, rdata: 32'hDEADBEEF});
    tick();
    cmd_valid = 0;
    tick();
    chk("rd ACCESS", {PSEL, PENABLE}, 2'b11);
    tick();
    chk("rd RDWAIT", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0000);
    tick();
    chk("rd rsp_valid", rsp_valid, 1);

    // Lag-0 read with three wait cycles
    use_direct = 1; direct_rdata = 32'h12345678; PREADY = 0;
    cmd_valid0 = 1; cmd_write = 0; cmd_addr = 8'h24;
    q0.push_back('{err: 1'b0, chk_data: 1'b1, rdata: 32'h12345678});
    tick();
    cmd_valid0 = 0;
    base = n_access0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lag0 ACCESS held", {PSEL0, PENABLE0, PADDR0}, {2'b11, 8'h24});
      if (i == 3) PREADY = 1;
    end
    tick();
    chk("lag0 rsp_valid", rsp_valid0, 1);
    chk("lag0 access cycles", n_access0 - base, 4);
    use_direct = 0;

    // PREADY stuck low: timeout abort after 16 ACCESS cycles
    PREADY = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h30; cmd_wdata = 32'h1;
    q1.push_back('{err: 1'b1, chk_data: 1'b1, rdata: 32'h0});
    tick();
    cmd_valid = 0;
    base = n_access;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (rsp_valid) done = 1;
    end
    chk("timeout seen", done, 1);
    chk("timeout access cycles", n_access - base, 16);
    chk("timeout PSEL/PENABLE", {PSEL, PENABLE}, 2'b00);

    // PREADY rises exactly on the 16th ACCESS edge: normal completion
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h40; cmd_wdata = 32'h2;
    q1.push_back('{err: 1'b0, chk_data: 1'b0, rdata: 32'h0});
    tick();
    cmd_valid = 0;
    base = n_access;
    for (int i = 0; i < 16; i++) tick();
    chk("edge16 still busy", rsp_valid, 0);
    PREADY = 1;
    tick();
    chk("edge16 rsp_valid", rsp_valid, 1);
    chk("edge16 access cycles", n_access - base, 16);

    // Back-to-back writes with cmd_valid held
    base = acc_cnt; base2 = n_setup;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h50; cmd_wdata = 32'h0BADCAFE;
    q1.push_back('{err: 1'b0, chk_data: 1'b0, rdata: 32'h0});
    q1.push_back('{err: 1'b0, chk_data: 1'b0, rdata: 32'h0});
    for (int i = 0; i < 6; i++) tick();
    cmd_valid = 0;
    chk("b2b accepts", acc_cnt - base, 2);
    chk("b2b accept gap", acc_gap, 3);
    chk("b2b setups", n_setup - base2, 2);
    chk("b2b responses drained", q1.size(), 0);

    // Reset pulsed during ACCESS
    PREADY = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h60; cmd_wdata = 32'h3;
    tick();
    cmd_valid = 0;
    tick();
    chk("pre-reset ACCESS", {PSEL, PENABLE}, 2'b11);
    #2 PRESETn = 0;
    #1;
    chk("async reset", {PSEL, PENABLE, cmd_ready}, 3'b001);
    tick(); tick();
    PRESETn = 1; PREADY = 1;
    tick();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h70; cmd_wdata = 32'hCAFEF00D;
    q1.push_back('{err: 1'b0, chk_data: 1'b0, rdata: 32'h0});
    tick();
    cmd_valid = 0;
    chk("post-reset SETUP", {PSEL, PENABLE, PADDR}, {2'b10, 8'h70});
    tick(); tick();
    chk("post-reset rsp_valid", rsp_valid, 1);

    tick(); tick(); tick();
    chk("all responses seen", q1.size() + q0.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
